// File: rtl/ps2_key_event_decoder_pkg.sv
// Shared scancode constants, event layout and decoder state encoding for the
// PS/2 key event decoder.
package ps2_pkg;

  // Scancode prefixes
  localparam logic [7:0] SC_E0 = 8'hE0;
  localparam logic [7:0] SC_F0 = 8'hF0;
  localparam logic [7:0] SC_E1 = 8'hE1;

  // Keyboard housekeeping bytes that never form part of a key sequence
  localparam logic [7:0] SC_NUL    = 8'h00;
  localparam logic [7:0] SC_BAT_OK = 8'hAA;
  localparam logic [7:0] SC_ACK    = 8'hFA;
  localparam logic [7:0] SC_RESEND = 8'hFE;
  localparam logic [7:0] SC_ERR    = 8'hFF;

  // Modifier and lock key codes
  localparam logic [7:0] SC_SHIFT_L = 8'h12;
  localparam logic [7:0] SC_SHIFT_R = 8'h59;
  localparam logic [7:0] SC_CTRL    = 8'h14;
  localparam logic [7:0] SC_ALT     = 8'h11;
  localparam logic [7:0] SC_CAPS    = 8'h58;
  localparam logic [7:0] SC_NUM     = 8'h77;

  // Event word {brk, ext, code[7:0]}
  localparam int EV_W   = 10;
  localparam int EV_BRK = 9;
  localparam int EV_EXT = 8;

  // mods bit positions
  localparam int MOD_W       = 6;
  localparam int MOD_SHIFT_L = 0;
  localparam int MOD_SHIFT_R = 1;
  localparam int MOD_CTRL_L  = 2;
  localparam int MOD_CTRL_R  = 3;
  localparam int MOD_ALT_L   = 4;
  localparam int MOD_ALT_R   = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_PAUSE
  } state_t;

  function automatic logic is_ignored(input logic [7:0] c);
    return (c == SC_NUL) || (c == SC_BAT_OK) || (c == SC_ACK) ||
           (c == SC_RESEND) || (c == SC_ERR);
  endfunction

endpackage

// File: rtl/ps2_key_event_decoder_if.sv
// Byte-in / event-out bus of the key event decoder. master is the
// receiver+consumer side, slave is the decoder.
interface ps2_key_event_if;
  import ps2_pkg::*;

  logic [7:0]      scan_code;
  logic            scan_valid;
  logic [EV_W-1:0] ev_data;
  logic            ev_valid;
  logic            ev_ready;

  modport master (
    output scan_code, scan_valid, ev_ready,
    input  ev_data, ev_valid
  );

  modport slave (
    input  scan_code, scan_valid, ev_ready,
    output ev_data, ev_valid
  );
endinterface

// File: rtl/ps2_event_fifo.sv
// Show-ahead event queue. Writes into a full queue succeed only when a pop
// happens in the same cycle; the parent accounts for dropped events.
module ps2_event_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic do_wr, do_rd;

  // Pointers carry one extra wrap bit to tell full from empty
  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | do_rd);
  assign rd_data = empty ? '0 : mem[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_wr) wr_d = wr_q + PTR_ONE;
    if (do_rd) rd_d = rd_q + PTR_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_q[AW-1:0]] <= wr_data;
  end
endmodule

// File: rtl/ps2_key_event_decoder.sv
// Turns the PS/2 scancode byte stream into queued {brk, ext, code} events and
// tracks modifier, lock and keypress state alongside.
module ps2_key_event_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH    = 8,
  parameter int COUNT_WIDTH   = 8,
  parameter int REPEAT_FILTER = 1
) (
  input  logic                   CLK100MHZ,
  input  logic                   CPU_RESETN,
  ps2_key_event_if.slave         bus,
  output logic [MOD_W-1:0]       mods,
  output logic                   caps_lock,
  output logic                   num_lock,
  output logic [COUNT_WIDTH-1:0] key_count,
  output logic                   overflow,
  input  logic                   clr_ovf
);
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  state_t state_q, state_d;
  logic [2:0] skip_q, skip_d;
  logic [8:0] last_q, last_d;
  logic last_vld_q, last_vld_d;
  logic [MOD_W-1:0] mods_q, mods_d;
  logic caps_q, caps_d, num_q, num_d, ovf_q, ovf_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;

  logic emit, e_brk, e_ext, is_rep, accept, pop, fifo_full, fifo_empty;
  logic [7:0] e_code;

  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    emit    = 1'b0;
    e_brk   = 1'b0;
    e_ext   = 1'b0;
    e_code  = bus.scan_code;
    if (bus.scan_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.scan_code == SC_E0)      state_d = ST_EXT;
          else if (bus.scan_code == SC_F0) state_d = ST_BRK;
          else if (bus.scan_code == SC_E1) begin
            state_d = ST_PAUSE;
            skip_d  = 3'd7;
          end else if (!is_ignored(bus.scan_code)) emit = 1'b1;
        end
        ST_EXT: begin
          state_d = ST_IDLE;
          if (bus.scan_code == SC_F0) state_d = ST_EXT_BRK;
          else if (bus.scan_code != SC_E0 && bus.scan_code != SC_E1) begin
            emit  = 1'b1;
            e_ext = 1'b1;
          end
        end
        ST_BRK, ST_EXT_BRK: begin
          state_d = ST_IDLE;
          if (bus.scan_code != SC_E0 && bus.scan_code != SC_E1 &&
              bus.scan_code != SC_F0) begin
            emit  = 1'b1;
            e_brk = 1'b1;
            e_ext = (state_q == ST_EXT_BRK);
          end
        end
        ST_PAUSE: begin
          // Pause has no break code; the tail bytes are swallowed and one make reported
          skip_d = skip_q - 3'd1;
          if (skip_q == 3'd1) begin
            state_d = ST_IDLE;
            emit    = 1'b1;
            e_code  = SC_E1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign is_rep = (REPEAT_FILTER != 0) && emit && !e_brk && last_vld_q &&
                  (last_q == {e_ext, e_code});
  assign accept = emit & ~is_rep;
  assign pop    = bus.ev_ready & ~fifo_empty;

  always_comb begin
    last_d     = last_q;
    last_vld_d = last_vld_q;
    mods_d     = mods_q;
    caps_d     = caps_q;
    num_d      = num_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q & ~clr_ovf;
    if (accept) begin
      if (e_brk) last_vld_d = 1'b0;
      else begin
        last_d     = {e_ext, e_code};
        last_vld_d = 1'b1;
        cnt_d      = cnt_q + CNT_ONE;
        if (!e_ext && e_code == SC_CAPS) caps_d = ~caps_q;
        if (!e_ext && e_code == SC_NUM)  num_d  = ~num_q;
      end
      case (e_code)
        SC_SHIFT_L: mods_d[MOD_SHIFT_L] = ~e_brk;
        SC_SHIFT_R: mods_d[MOD_SHIFT_R] = ~e_brk;
        SC_CTRL:    mods_d[e_ext ? MOD_CTRL_R : MOD_CTRL_L] = ~e_brk;
        SC_ALT:     mods_d[e_ext ? MOD_ALT_R : MOD_ALT_L]   = ~e_brk;
        default: ;
      endcase
      if (fifo_full && !pop) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_q    <= ST_IDLE;
      skip_q     <= '0;
      last_q     <= '0;
      last_vld_q <= 1'b0;
      mods_q     <= '0;
      caps_q     <= 1'b0;
      num_q      <= 1'b0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      skip_q     <= skip_d;
      last_q     <= last_d;
      last_vld_q <= last_vld_d;
      mods_q     <= mods_d;
      caps_q     <= caps_d;
      num_q      <= num_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  ps2_event_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(EV_W)) u_fifo (
    .clk    (CLK100MHZ),
    .rst_n  (CPU_RESETN),
    .wr_en  (accept),
    .wr_data({e_brk, e_ext, e_code}),
    .rd_en  (bus.ev_ready),
    .rd_data(bus.ev_data),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign bus.ev_valid = ~fifo_empty;
  assign mods      = mods_q;
  assign caps_lock = caps_q;
  assign num_lock  = num_q;
  assign key_count = cnt_q;
  assign overflow  = ovf_q;
endmodule

// File: doc/ps2_key_event_decoder.md
# ps2_key_event_decoder

- Decodes the byte stream from the PS/2 receiver into typed key events.
- Handles make, break, E0-extended and the E1 Pause sequence.
- Filters typematic auto-repeat and tracks modifier and lock state.
- Queues events in a parametrised FIFO with a valid/ready pop interface.
- Sits between `PS2Receiver` and the display/ASCII consumers, replacing ad-hoc scancode bookkeeping in top-level glue.

## Interface

Parameters:
- `FIFO_DEPTH`, 8, event queue entries; power of two, ≥2.
- `COUNT_WIDTH`, 8, width of the accepted-keypress counter.
- `REPEAT_FILTER`, 1, 1 drops auto-repeat makes; 0 forwards every make.

Ports:
- `CLK100MHZ` input 1: system clock.
- `CPU_RESETN` input 1: reset. Asynchronous assert, active-low.
- `scan_code` input 8: byte from the receiver.
- `scan_valid` input 1: one-cycle strobe qualifying `scan_code`.
- `ev_data` output 10: head event `{brk, ext, code[7:0]}`.
- `ev_valid` output 1: FIFO non-empty.
- `ev_ready` input 1: consumer pops the head when `ev_valid & ev_ready`.
- `mods` output 6: held modifiers `{alt_r, alt_l, ctrl_r, ctrl_l, shift_r, shift_l}`.
- `caps_lock` output 1: toggled lock level.
- `num_lock` output 1: toggled lock level.
- `key_count` output COUNT_WIDTH: accepted (non-repeat) make events; wraps.
- `overflow` output 1: sticky; set when an event is dropped because the FIFO is full.
- `clr_ovf` input 1: clears `overflow`.

## Operation

Decoder FSM (advances only on `scan_valid`):
- **IDLE**
  - E0 → EXT.
  - F0 → BRK.
  - E1 → PAUSE with skip counter = 7.
  - 00/AA/FA/FE/FF → ignored.
  - Any other byte → emit make {0,0,code}; stay IDLE.
- **EXT**
  - F0 → EXT_BRK.
  - E0/E1 → IDLE, byte discarded (protocol error).
  - Else → emit make {0,1,code}, go IDLE.
- **BRK**
  - E0/E1/F0 → IDLE, discarded.
  - Else → emit break {1,0,code}, go IDLE.
- **EXT_BRK**
  - E0/E1/F0 → IDLE, discarded.
  - Else → emit break {1,1,code}, go IDLE.
- **PAUSE**
  - Decrement the skip counter on each byte.
  - On the byte that reaches 0 → emit make {0,0,8'hE1}, go IDLE.
  - No break event is ever emitted for Pause.

Repeat filter (REPEAT_FILTER=1):
- `last_make` register holds {ext, code} plus a valid bit.
- A make equal to `last_make` while the valid bit is set is a repeat. It is dropped entirely: no FIFO write, no count, no lock toggle.
- Any break clears the valid bit.
- Any accepted make loads `last_make`.

Modifier and lock updates on emitted events:
- 12 sets/clears `shift_l`.
- 59 sets/clears `shift_r`.
- 14 sets/clears `ctrl_l`; E0 14 sets/clears `ctrl_r`.
- 11 sets/clears `alt_l`; E0 11 sets/clears `alt_r`.
- Non-extended 58 make toggles `caps_lock`.
- Non-extended 77 make toggles `num_lock`.
- Modifier and lock events are also queued.

Counter and overflow:
- `key_count` increments on every accepted make, including Pause; it wraps modulo 2^COUNT_WIDTH.
- `overflow` set-dominates: set and `clr_ovf` in the same cycle leaves it set.

## Timing

Reset values:
- FSM = IDLE; `last_make` invalid.
- `mods` = 0, `caps_lock` = 0, `num_lock` = 0.
- `key_count` = 0, `overflow` = 0.
- FIFO empty, so `ev_valid` = 0; `ev_data` = 0.

Latency:
- The event is written on the edge that samples the final byte's `scan_valid`.
- `ev_valid` rises the following cycle.
- `mods`, locks and `key_count` update on that same write edge, i.e. visible one cycle after the strobe.

FIFO behaviour:
- First-word fall-through: `ev_data` is valid whenever `ev_valid` is high, and is stable until popped.
- Push and pop in the same cycle when full: both succeed, no overflow.
- Push when full with no pop: event dropped, `overflow` set. Modifier/lock/count updates still apply.
- Pop when empty: ignored.

Reset mid-sequence (e.g. after E0): FSM returns to IDLE asynchronously and the partial sequence is lost.

## Structure

Package `ps2_pkg`:
- Prefix constants E0, F0, E1.
- Ignored-code constants.
- Modifier code constants.
- Event field width (10) and bit indices.
- `mods` bit indices.
- FSM state encoding.

Sub-module `ps2_event_fifo`:
- Parametrised by depth and width.
- Show-ahead, valid/ready pop, `full`/`empty` outputs, drop-on-full handled by the parent.

## Test plan

- Stream 1C, F0 1C → events {0,0,1C} then {1,0,1C}; `key_count`=1; `ev_valid` one cycle after the 1C strobe.
- Stream 1C 1C 1C, F0 1C with REPEAT_FILTER=1 → two events; `key_count`=1. With REPEAT_FILTER=0 → four events; `key_count`=3.
- Stream E0 14, 12, E0 F0 14, F0 12 → `mods` goes 0x08, 0x09, 0x01, 0x00; events carry `ext`=1 for the 14s.
- Stream E1 14 77 E1 F0 14 F0 77 → single event {0,0,E1}; `num_lock` unchanged. Then 58, F0 58 → `caps_lock`=1.
- FIFO_DEPTH=4 with `ev_ready`=0 and 5 makes → 4 queued; `overflow`=1. Pop plus push while full → no further drop. `clr_ovf` → `overflow`=0.
- Assert `CPU_RESETN`=0 after E0 → all outputs at reset values. Next byte 1C → event {0,0,1C}.
